// File: rtl/step_gen_io_pkg.sv
// Shared definitions for the step/direction generator.
//   - default field widths
//   - register word offsets (byte offset >> 2)
//   - CTRL / STATUS bit positions
//   - pulse FSM state encoding
//   - byte-strobe merge helper
package step_gen_io_pkg;

    localparam int PERIOD_W_DEF = 24;
    localparam int PULSE_W_DEF  = 16;
    localparam int COUNT_W_DEF  = 32;

    // Word offsets within the block
    localparam logic [5:0] REG_CTRL     = 6'h00;
    localparam logic [5:0] REG_PERIOD   = 6'h01;
    localparam logic [5:0] REG_PULSE    = 6'h02;
    localparam logic [5:0] REG_STEPS    = 6'h03;
    localparam logic [5:0] REG_STATUS   = 6'h04;
    localparam logic [5:0] REG_POSITION = 6'h05;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_DIR_BIT   = 1;
    localparam int CTRL_ABORT_BIT = 2;
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } step_state_e;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] merge_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/step_gen_io_pulse_fsm.sv
// step_pulse_fsm: IDLE/HIGH/LOW pulse sequencer with phase counter,
// remaining-step counter and signed position counter.
//   clk_in, reset_in      clock, async active-high reset
//   enable_i, dir_i       CTRL.enable / CTRL.dir register values
//   abort_i               one-cycle abort strobe (bus commit edge)
//   period_i, pulse_i     step period / high-time in clk cycles
//   load_i, load_value_i  STEPS write strobe and merged value
//   pos_wr_i, pos_value_i POSITION write strobe and merged value
//   step_o, dir_o         driver pins
//   busy_o, done_set_o    running flag, one-cycle run-complete strobe
//   remaining_o           steps still to issue
//   position_o            signed step position
module step_pulse_fsm
    import step_gen_io_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int PULSE_W  = PULSE_W_DEF,
    parameter int COUNT_W  = COUNT_W_DEF
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                enable_i,
    input  logic                dir_i,
    input  logic                abort_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [PULSE_W-1:0]  pulse_i,
    input  logic                load_i,
    input  logic [COUNT_W-1:0]  load_value_i,
    input  logic                pos_wr_i,
    input  logic [31:0]         pos_value_i,
    output logic                step_o,
    output logic                dir_o,
    output logic                busy_o,
    output logic                done_set_o,
    output logic [COUNT_W-1:0]  remaining_o,
    output logic [31:0]         position_o
);

    // Phase counter wide enough for both PERIOD and PULSE+1
    localparam int CW = (PERIOD_W > PULSE_W + 1) ? PERIOD_W : PULSE_W + 1;

    step_state_e        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [31:0]        pos_q, pos_d;
    logic               dir_q, dir_d;

    logic [CW-1:0] hi_len, per_eff, lo_raw, lo_len;
    logic          kill, enter_high;

    // HIGH = max(PULSE,1); whole period = max(PERIOD,PULSE+1); LOW >= 1
    always_comb begin
        hi_len  = (pulse_i == '0) ? CW'(1) : CW'(pulse_i);
        per_eff = (CW'(period_i) > CW'(pulse_i) + CW'(1)) ? CW'(period_i)
                                                          : CW'(pulse_i) + CW'(1);
        lo_raw  = per_eff - hi_len;
        lo_len  = (lo_raw == '0) ? CW'(1) : lo_raw;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        done_set_o = 1'b0;
        enter_high = 1'b0;
        kill       = abort_i | (!enable_i && state_q != ST_IDLE);

        if (kill) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rem_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_i && rem_q != '0) begin
                        state_d    = ST_HIGH;
                        dir_d      = dir_i;
                        enter_high = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == '0) begin
                        state_d = ST_LOW;
                        cnt_d   = lo_len - CW'(1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_LOW: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (rem_q != '0) begin
                        state_d    = ST_HIGH;
                        enter_high = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        done_set_o = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Each step is counted as it starts; entry implies rem_q != 0
            if (enter_high) begin
                cnt_d = hi_len - CW'(1);
                rem_d = rem_q - COUNT_W'(1);
                pos_d = dir_d ? pos_q - 32'd1 : pos_q + 32'd1;
            end
        end

        // Bus writes override the sequencer's own updates
        if (load_i)   rem_d = load_value_i;
        if (pos_wr_i) pos_d = pos_value_i;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
        end
    end

    assign step_o      = (state_q == ST_HIGH);
    assign dir_o       = dir_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign remaining_o = rem_q;
    assign position_o  = pos_q;

endmodule

// File: rtl/step_gen_io.sv
// step_gen_io: picorv32 native-bus responder driving a stepper driver.
//   clk_in, reset_in      clock, async active-high reset
//   valid_in, addr_in     request and byte offset (bits [1:0] ignored)
//   wdata_in, wstrb_in    write data and byte enables (0 = read)
//   ready_out, rdata_out  one-cycle ack; read data is 0 outside the ack
//   step_out, dir_out     STEP / DIR pins
//   driver_en_n_out       active-low driver enable (= !CTRL.enable)
//   done_irq_out          level copy of STATUS.done
module step_gen_io
    import step_gen_io_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int PULSE_W  = PULSE_W_DEF,
    parameter int COUNT_W  = COUNT_W_DEF
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        valid_in,
    input  logic [7:0]  addr_in,
    input  logic [31:0] wdata_in,
    input  logic [3:0]  wstrb_in,
    output logic        ready_out,
    output logic [31:0] rdata_out,
    output logic        step_out,
    output logic        dir_out,
    output logic        driver_en_n_out,
    output logic        done_irq_out
);

    logic                ready_q, ctrl_en_q, ctrl_dir_q, done_q;
    logic [31:0]         rdata_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PULSE_W-1:0]  pulse_q;

    logic               access, wr;
    logic [5:0]         word;
    logic [31:0]        rd_val, merged;
    logic               busy, done_set, abort, load, pos_wr, done_clr;
    logic [COUNT_W-1:0] remaining;
    logic [31:0]        position;

    // A request is serviced once: on the edge that raises ready
    assign access = valid_in & ~ready_q;
    assign wr     = access & (wstrb_in != 4'b0000);
    assign word   = addr_in[7:2];

    always_comb begin
        rd_val = 32'd0;
        case (word)
            REG_CTRL:     rd_val = {30'd0, ctrl_dir_q, ctrl_en_q};
            REG_PERIOD:   rd_val = 32'(period_q);
            REG_PULSE:    rd_val = 32'(pulse_q);
            REG_STEPS:    rd_val = 32'(remaining);
            REG_STATUS:   rd_val = {30'd0, done_q, busy};
            REG_POSITION: rd_val = position;
            default:      rd_val = 32'd0;
        endcase
    end

    assign merged   = merge_wstrb(rd_val, wdata_in, wstrb_in);
    assign abort    = wr && word == REG_CTRL && wstrb_in[0] && wdata_in[CTRL_ABORT_BIT];
    assign load     = wr && word == REG_STEPS;
    assign pos_wr   = wr && word == REG_POSITION;
    assign done_clr = wr && word == REG_STATUS && wstrb_in[0] && wdata_in[STAT_DONE_BIT];

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
            ctrl_en_q  <= 1'b0;
            ctrl_dir_q <= 1'b0;
            period_q   <= '0;
            pulse_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            ready_q <= access;
            rdata_q <= (access && wstrb_in == 4'b0000) ? rd_val : 32'd0;
            if (wr && word == REG_CTRL) begin
                ctrl_en_q  <= merged[CTRL_EN_BIT];
                ctrl_dir_q <= merged[CTRL_DIR_BIT];
            end
            if (wr && word == REG_PERIOD) period_q <= merged[PERIOD_W-1:0];
            if (wr && word == REG_PULSE)  pulse_q  <= merged[PULSE_W-1:0];
            // Set has priority over a simultaneous write-1-clear
            if (done_set)      done_q <= 1'b1;
            else if (done_clr) done_q <= 1'b0;
        end
    end

    step_pulse_fsm #(
        .PERIOD_W (PERIOD_W),
        .PULSE_W  (PULSE_W),
        .COUNT_W  (COUNT_W)
    ) u_fsm (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .enable_i     (ctrl_en_q),
        .dir_i        (ctrl_dir_q),
        .abort_i      (abort),
        .period_i     (period_q),
        .pulse_i      (pulse_q),
        .load_i       (load),
        .load_value_i (merged[COUNT_W-1:0]),
        .pos_wr_i     (pos_wr),
        .pos_value_i  (merged),
        .step_o       (step_out),
        .dir_o        (dir_out),
        .busy_o       (busy),
        .done_set_o   (done_set),
        .remaining_o  (remaining),
        .position_o   (position)
    );

    // Address bits [1:0] carry no information for word registers
    logic unused_bits;
    assign unused_bits = ^addr_in[1:0];

    assign ready_out       = ready_q;
    assign rdata_out       = rdata_q;
    assign driver_en_n_out = ~ctrl_en_q;
    assign done_irq_out    = done_q;

endmodule

// File: tb/tb_step_gen_io.sv
module tb_step_gen_io;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;
    logic        step, dir, en_n, irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    step_gen_io dut (
        .clk_in          (clk),
        .reset_in        (rst),
        .valid_in        (valid),
        .addr_in         (addr),
        .wdata_in        (wdata),
        .wstrb_in        (wstrb),
        .ready_out       (ready),
        .rdata_out       (rdata),
        .step_out        (step),
        .dir_out         (dir),
        .driver_en_n_out (en_n),
        .done_irq_out    (irq)
    );

    localparam logic [7:0] A_CTRL = 8'h00, A_PERIOD = 8'h04, A_PULSE = 8'h08,
                           A_STEPS = 8'h0C, A_STATUS = 8'h10, A_POS = 8'h14;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Returns at posedge+1 of the acknowledging cycle
    task automatic bus_xfer(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        int n;
        @(negedge clk);
        addr = a; wdata = d; wstrb = s; valid = 1'b1; n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ready && n < 8);
        if (!ready) check("bus_ack_timeout", 64'(ready), 64'd1);
        rd = rdata;
        valid = 1'b0; wstrb = 4'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(a, d, 4'hF, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_xfer(a, 32'd0, 4'h0, v);
        check(tag, 64'(v), 64'(exp));
    endtask

    // Wait for step_out high, bounded
    task automatic wait_step_high(input string tag);
        int n = 0;
        while (!step && n < 200) begin @(posedge clk); #1; n++; end
        if (!step) check(tag, 64'(step), 64'd1);
    endtask

    initial begin
        logic [63:0] pat, exp_pat;
        logic [31:0] v;
        int falls, highs, pulses, bad;
        logic prev;

        rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;

        // 1. reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {58'd0, ready, step, dir, en_n, irq, |rdata},
              {58'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        @(negedge clk); rst = 1'b0;
        rd_check("rst_ctrl",   A_CTRL,   0);
        rd_check("rst_period", A_PERIOD, 0);
        rd_check("rst_pulse",  A_PULSE,  0);
        rd_check("rst_steps",  A_STEPS,  0);
        rd_check("rst_status", A_STATUS, 0);
        rd_check("rst_pos",    A_POS,    0);

        // 2. forward run: 4 steps, 3 high / 7 low
        wr(A_CTRL, 1); wr(A_PERIOD, 10); wr(A_PULSE, 3);
        check("t2_drv_en_n", 64'(en_n), 64'd0);
        wr(A_STEPS, 4);
        check("t2_low_at_ack", 64'(step), 64'd0);
        pat = '0; exp_pat = '0;
        for (int k = 0; k < 44; k++) begin
            @(posedge clk); #1;
            pat[k] = step;
            exp_pat[k] = (k < 40) && (k % 10 < 3);
        end
        check("t2_pulse_train", pat, exp_pat);
        check("t2_dir", 64'(dir), 64'd0);
        rd_check("t2_position", A_POS, 4);
        rd_check("t2_status", A_STATUS, 32'h2);
        check("t2_irq", 64'(irq), 64'd1);
        // STEPS=0: no run, done stays set
        wr(A_STEPS, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t2_steps0_idle", 64'(step), 64'd0);
        rd_check("t2_steps0_status", A_STATUS, 32'h2);

        // 3. reverse run with period clamp: 5 high / 1 low
        wr(A_POS, 0); wr(A_CTRL, 3); wr(A_PERIOD, 2); wr(A_PULSE, 5);
        wr(A_STEPS, 2);
        pat = '0; exp_pat = '0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            pat[k] = step;
            exp_pat[k] = (k < 12) && (k % 6 < 5);
            if (k == 0) check("t3_dir_at_rise", 64'({dir, step}), 64'b11);
        end
        check("t3_pulse_train", pat, exp_pat);
        rd_check("t3_position", A_POS, 32'hFFFF_FFFE);

        // 4. abort after third pulse
        wr(A_CTRL, 1); wr(A_PERIOD, 10); wr(A_PULSE, 3); wr(A_POS, 0);
        wr(A_STATUS, 32'h2);
        check("t4_irq_cleared", 64'(irq), 64'd0);
        wr(A_STEPS, 100);
        falls = 0; prev = step;
        for (int n = 0; n < 200 && falls < 3; n++) begin
            @(posedge clk); #1;
            if (prev && !step) falls++;
            prev = step;
        end
        check("t4_three_pulses", 64'(falls), 64'd3);
        wr(A_CTRL, 5);
        highs = 0;
        for (int n = 0; n < 20; n++) begin @(posedge clk); #1; if (step) highs++; end
        check("t4_no_more_steps", 64'(highs), 64'd0);
        rd_check("t4_status", A_STATUS, 0);
        rd_check("t4_steps", A_STEPS, 0);
        rd_check("t4_position", A_POS, 3);
        rd_check("t4_ctrl_abort_reads0", A_CTRL, 1);
        // abort during HIGH: step falls at the commit edge
        wr(A_STEPS, 5);
        wait_step_high("t4b_rise_timeout");
        wr(A_CTRL, 5);
        check("t4b_step_killed", 64'(step), 64'd0);
        rd_check("t4b_position", A_POS, 4);
        check("t4b_no_done", 64'(irq), 64'd0);

        // 5. bus behaviour
        @(negedge clk);
        addr = A_PERIOD; wstrb = 4'h0; valid = 1'b1;
        pulses = 0; bad = 0; v = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready) begin pulses++; v = rdata; end
            else if (rdata != 0) bad++;
            if (i == 1) valid = 1'b0;
        end
        check("t5_single_ready", 64'(pulses), 64'd1);
        check("t5_read_data", 64'(v), 64'd10);
        check("t5_rdata_zero_idle", 64'(bad), 64'd0);
        wr(8'h3C, 32'hDEAD_BEEF);
        rd_check("t5_unmapped", 8'h3C, 0);
        wr(A_PERIOD, 0);
        bus_xfer(A_PERIOD, 32'hFFFF_FFFF, 4'b0001, v);
        rd_check("t5_wstrb_byte0", A_PERIOD, 32'h0000_00FF);

        // 6. async reset during HIGH
        wr(A_PERIOD, 20); wr(A_PULSE, 8); wr(A_CTRL, 1); wr(A_STEPS, 3);
        wait_step_high("t6_rise_timeout");
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("t6_async_step", 64'({step, en_n}), 64'b01);
        @(negedge clk); rst = 1'b0;
        rd_check("t6_status", A_STATUS, 0);
        rd_check("t6_steps", A_STEPS, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
